mdiv_div_ctrl: RTL and testbench

Sequencer and two-port arbiter in front of the shared `hp_int_div` in the mdiv execute unit. Accepts RISC-V DIV/DIVU/REM/REMU and their W variants from two requesters. Round-robin arbitration picks one request; the block extends the operands to the divider width and drives the divider handshake. It returns the selected, width-corrected result with the request tag, and handles pipeline flush while a divide is in flight.

---
 rtl/mdiv_pkg.sv | 25 ++
 rtl/mdiv_div_ctrl_if.sv | 32 +++
 rtl/mdiv_rr_arb2.sv | 30 +++
 rtl/mdiv_div_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mdiv_div_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdiv_pkg.sv
// Shared definitions for the mdiv divide sequencer: op bit positions, FSM states,
// and the divider operand width derived from XLEN.
package mdiv_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned OP_W     = 3;

    // Request op is {word, rem, unsigned}
    localparam int unsigned OP_WORD = 2;
    localparam int unsigned OP_REM  = 1;
    localparam int unsigned OP_UNS  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // One extra bit so unsigned XLEN operands divide correctly on a signed divider
    function automatic int unsigned div_width(input int unsigned xlen);
        return xlen + 1;
    endfunction

endpackage

// File: rtl/mdiv_div_ctrl_if.sv
// Requester/response bundle for mdiv_div_ctrl: two request ports, flush and one response port.
interface mdiv_div_ctrl_if
    import mdiv_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 8
);

    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [1:0][OP_W-1:0]       req_op;
    logic [1:0][XLEN-1:0]       req_a;
    logic [1:0][XLEN-1:0]       req_b;
    logic [1:0][TAG_W-1:0]      req_tag;
    logic                       flush;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [XLEN-1:0]            rsp_data;
    logic [TAG_W-1:0]           rsp_tag;
    logic                       rsp_port;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_port
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_port
    );

endinterface

// File: rtl/mdiv_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves past the winner on every accept.
module mdiv_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic ptr_q;

    // Pointer port wins only when both request
    always_comb begin
        grant_o = 2'b00;
        if (valid_i == 2'b11) begin
            grant_o[ptr_q] = 1'b1;
        end else begin
            grant_o = valid_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (accept_i) begin
            ptr_q <= ~grant_o[1];
        end
    end

endmodule

// File: rtl/mdiv_div_ctrl.sv
// Two-port sequencer in front of the shared hp_int_div: arbitrates, extends operands,
// formats results and handles flush. Optional MDIV_DIV_ZERO_FAST_EN bypasses the divider on /0.
module mdiv_div_ctrl
    import mdiv_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned DIV_WIDTH = div_width(XLEN),
    parameter int unsigned TAG_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mdiv_div_ctrl_if.slave       bus,
    output logic [DIV_WIDTH-1:0] div_dived_o,
    output logic [DIV_WIDTH-1:0] div_divor_o,
    output logic                 div_signed_o,
    output logic                 div_in_valid_o,
    input  logic                 div_in_ready_i,
    input  logic [DIV_WIDTH-1:0] div_res_i,
    input  logic [DIV_WIDTH-1:0] div_rem_i,
    input  logic                 div_out_valid_i,
    output logic                 div_out_ready_o
);

    localparam int unsigned HI_W  = XLEN - 32;
    localparam int unsigned EXT_W = DIV_WIDTH - XLEN;

    state_e               state_q;
    logic [OP_W-1:0]      op_q;
    logic [DIV_WIDTH-1:0] dived_q;
    logic [DIV_WIDTH-1:0] divor_q;
    logic                 signed_q;
    logic [TAG_W-1:0]     tag_q;
    logic                 port_q;
    logic                 killed_q;
    logic [XLEN-1:0]      res_q;
    logic                 rsp_valid_q;
    logic                 in_valid_q;
    logic                 out_ready_q;

    logic [1:0]           grant;
    logic                 accept;
    logic                 sel_port;
    logic [OP_W-1:0]      sel_op;
    logic [XLEN-1:0]      sel_a;
    logic [XLEN-1:0]      sel_b;
    logic [DIV_WIDTH-1:0] dived_d;
    logic [DIV_WIDTH-1:0] divor_d;
    logic [XLEN-1:0]      pick;
    logic [XLEN-1:0]      result_d;
    logic                 unused_hi;

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        return {{HI_W{v[31]}}, v[31:0]};
    endfunction

    // Word ops use only the low 32 bits; the sign source follows the operand width
    function automatic logic [DIV_WIDTH-1:0] extend(input logic [XLEN-1:0] v,
                                                    input logic word,
                                                    input logic uns);
        logic            sign;
        logic [XLEN-1:0] lo;
        sign = ~uns & (word ? v[31] : v[XLEN-1]);
        lo   = word ? {{HI_W{sign}}, v[31:0]} : v;
        return {{EXT_W{sign}}, lo};
    endfunction

    mdiv_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (bus.req_valid),
        .accept_i (accept),
        .grant_o  (grant)
    );

    assign bus.req_ready = grant & {2{(state_q == ST_IDLE) & ~bus.flush}};
    assign accept        = |(bus.req_ready & bus.req_valid);

    assign sel_port = grant[1];
    assign sel_op   = bus.req_op[sel_port];
    assign sel_a    = bus.req_a[sel_port];
    assign sel_b    = bus.req_b[sel_port];
    assign dived_d  = extend(sel_a, sel_op[OP_WORD], sel_op[OP_UNS]);
    assign divor_d  = extend(sel_b, sel_op[OP_WORD], sel_op[OP_UNS]);

    assign pick     = op_q[OP_REM] ? div_rem_i[XLEN-1:0] : div_res_i[XLEN-1:0];
    assign result_d = op_q[OP_WORD] ? sext_word(pick) : pick;

    // Extension bits carry no information once truncated back to XLEN
    assign unused_hi = ^{div_res_i[DIV_WIDTH-1:XLEN], div_rem_i[DIV_WIDTH-1:XLEN]};

`ifdef MDIV_DIV_ZERO_FAST_EN
    logic            divor_zero;
    logic [XLEN-1:0] zero_res_d;

    assign divor_zero = (divor_d == '0);
    assign zero_res_d = sel_op[OP_REM] ? (sel_op[OP_WORD] ? sext_word(sel_a) : sel_a) : '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            dived_q     <= '0;
            divor_q     <= '0;
            signed_q    <= 1'b0;
            tag_q       <= '0;
            port_q      <= 1'b0;
            killed_q    <= 1'b0;
            res_q       <= '0;
            rsp_valid_q <= 1'b0;
            in_valid_q  <= 1'b0;
            out_ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= sel_op;
                        dived_q  <= dived_d;
                        divor_q  <= divor_d;
                        signed_q <= ~sel_op[OP_UNS];
                        tag_q    <= bus.req_tag[sel_port];
                        port_q   <= sel_port;
                        killed_q <= 1'b0;
`ifdef MDIV_DIV_ZERO_FAST_EN
                        if (divor_zero) begin
                            res_q       <= zero_res_d;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            in_valid_q <= 1'b1;
                            state_q    <= ST_ISSUE;
                        end
`else
                        in_valid_q <= 1'b1;
                        state_q    <= ST_ISSUE;
`endif
                    end
                end
                ST_ISSUE: begin
                    // Once the divider has taken the operands, a flush must wait for its output
                    if (div_in_ready_i) begin
                        out_ready_q <= 1'b1;
                        state_q     <= ST_BUSY;
                        if (bus.flush) begin
                            killed_q <= 1'b1;
                        end
                    end else if (bus.flush) begin
                        in_valid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (div_out_valid_i) begin
                        in_valid_q  <= 1'b0;
                        out_ready_q <= 1'b0;
                        killed_q    <= 1'b0;
                        if (killed_q | bus.flush) begin
                            state_q <= ST_IDLE;
                        end else begin
                            res_q       <= result_d;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    end else if (bus.flush) begin
                        killed_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready | bus.flush) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign div_dived_o     = dived_q;
    assign div_divor_o     = divor_q;
    assign div_signed_o    = signed_q;
    assign div_in_valid_o  = in_valid_q;
    assign div_out_ready_o = out_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = res_q;
    assign bus.rsp_tag     = tag_q;
    assign bus.rsp_port    = port_q;

endmodule

// File: tb/tb_mdiv_div_ctrl.sv
// Bench for mdiv_div_ctrl with a behavioural divider; works with or without MDIV_DIV_ZERO_FAST_EN.
module tb_mdiv_div_ctrl;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DW    = 65;
    localparam int unsigned TAG_W = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] div_dived, div_divor, div_res, div_rem;
    logic          div_signed, div_in_valid, div_in_ready, div_out_valid, div_out_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic hold_in   = 1'b0;
    int   lat_force = 0;
    int   in_valid_cycles = 0;
    int   hs_count  = 0;
    logic dm_busy;
    int   dm_cnt;

    mdiv_div_ctrl_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    mdiv_div_ctrl #(.XLEN(XLEN), .DIV_WIDTH(DW), .TAG_W(TAG_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .div_dived_o     (div_dived),
        .div_divor_o     (div_divor),
        .div_signed_o    (div_signed),
        .div_in_valid_o  (div_in_valid),
        .div_in_ready_i  (div_in_ready),
        .div_res_i       (div_res),
        .div_rem_i       (div_rem),
        .div_out_valid_i (div_out_valid),
        .div_out_ready_o (div_out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural divider: truncating division, x/0 gives all ones and remainder x
    function automatic logic [2*DW-1:0] dm_calc(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                                 input logic sgn);
        logic [DW-1:0] q, r;
        if (y == '0) begin
            q = '1; r = x;
        end else if (sgn) begin
            q = DW'($signed(x) / $signed(y));
            r = DW'($signed(x) % $signed(y));
        end else begin
            q = x / y; r = x % y;
        end
        return {q, r};
    endfunction

    assign div_in_ready = ~dm_busy & ~hold_in;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_busy       <= 1'b0;
            div_out_valid <= 1'b0;
            dm_cnt        <= 0;
            div_res       <= '0;
            div_rem       <= '0;
        end else begin
            if (div_in_valid) in_valid_cycles <= in_valid_cycles + 1;
            if (!dm_busy) begin
                if (div_in_valid && div_in_ready) begin
                    dm_busy              <= 1'b1;
                    {div_res, div_rem}   <= dm_calc(div_dived, div_divor, div_signed);
                    dm_cnt               <= (lat_force != 0) ? lat_force : int'($urandom_range(1, 4));
                    hs_count             <= hs_count + 1;
                end
            end else if (!div_out_valid) begin
                if (dm_cnt <= 1) div_out_valid <= 1'b1;
                else dm_cnt <= dm_cnt - 1;
            end else if (div_out_ready) begin
                div_out_valid <= 1'b0;
                dm_busy       <= 1'b0;
            end
        end
    end

    // Reference: RISC-V M-extension division semantics in plain arithmetic
    function automatic logic [63:0] ref_div(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic        word, rem, uns;
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        word = op[2]; rem = op[1]; uns = op[0];
        a32 = a[31:0]; b32 = b[31:0];
        if (word) begin
            if (b32 == 32'd0)                                   r32 = rem ? a32 : 32'hFFFF_FFFF;
            else if (uns)                                       r32 = rem ? a32 % b32 : a32 / b32;
            else if (a32 == 32'h8000_0000 && b32 == '1)         r32 = rem ? 32'd0 : a32;
            else r32 = rem ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0)                                         r64 = rem ? a : '1;
        else if (uns)                                           r64 = rem ? a % b : a / b;
        else if (a == 64'h8000_0000_0000_0000 && b == '1)       r64 = rem ? 64'd0 : a;
        else r64 = rem ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
        return r64;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Present one request and hold it until accepted; t_acc is the accept cycle
    task automatic issue(input logic p, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [7:0] tag, input string nm,
                         output bit ok, output int t_acc);
        int n;
        @(negedge clk);
        bus.req_valid[p] = 1'b1;
        bus.req_op[p]    = op;
        bus.req_a[p]     = a;
        bus.req_b[p]     = b;
        bus.req_tag[p]   = tag;
        #1;
        n = 0;
        while (!bus.req_ready[p] && n < 100) begin
            @(negedge clk); #1; n++;
        end
        ok = bus.req_ready[p];
        t_acc = cyc;
        chk({"accept_", nm}, 64'(ok), 64'd1);
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic wait_rsp(input string nm, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 200) begin
            @(negedge clk); n++;
        end
        ok = bus.rsp_valid;
        chk({"rsp_wait_", nm}, 64'(ok), 64'd1);
    endtask

    task automatic do_req(input logic p, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [7:0] tag, input logic [63:0] exp,
                          input int stall, input string nm, output int lat);
        bit ok;
        int t_acc;
        lat = -1;
        bus.rsp_ready = (stall == 0);
        issue(p, op, a, b, tag, nm, ok, t_acc);
        if (!ok) begin bus.rsp_ready = 1'b1; return; end
        wait_rsp(nm, ok);
        if (!ok) begin bus.rsp_ready = 1'b1; return; end
        lat = cyc - t_acc;
        chk({nm, "_data"}, bus.rsp_data, exp);
        chk({nm, "_tag"},  64'(bus.rsp_tag), 64'(tag));
        chk({nm, "_port"}, 64'(bus.rsp_port), 64'(p));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, 64'(bus.rsp_valid), 64'd1);
            chk({nm, "_hold_data"},  bus.rsp_data, exp);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_rsp_drop"}, 64'(bus.rsp_valid), 64'd0);
    endtask

    typedef struct packed {
        logic        port;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [7:0]  tag;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int  lat, acc, rsp_n, n, cnt0, hs0;
        bit  ok, seen;
        int  t_acc;
        logic        rp;
        logic [2:0]  rop;
        logic [63:0] ra, rb;

        vecs[0] = '{1'b0, 3'b000, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 8'h5A, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[1] = '{1'b1, 3'b111, 64'h0000_0001_0000_0007, 64'd2, 8'h3C, 64'd1};
        vecs[2] = '{1'b0, 3'b001, 64'd100, 64'd7, 8'h01, 64'd14};
        vecs[3] = '{1'b1, 3'b010, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 8'h02, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[4] = '{1'b0, 3'b000, 64'd5, 64'd0, 8'h03, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{1'b1, 3'b110, 64'h0000_0001_8000_0005, 64'h0000_0007_0000_0000, 8'h04,
                    64'hFFFF_FFFF_8000_0005};
        vecs[6] = '{1'b1, 3'b101, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 8'h05, 64'h0000_0000_0FFF_FFFF};
        vecs[7] = '{1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 8'h06, 64'd5};
        vecs[8] = '{1'b1, 3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h07,
                    64'h8000_0000_0000_0000};

        bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
        bus.flush = 1'b0; bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_in_valid",  64'(div_in_valid),  64'd0);
        chk("rst_out_ready", 64'(div_out_ready), 64'd0);
        chk("rst_rsp_data",  bus.rsp_data,       64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);

        // Both ports requesting continuously: grants alternate starting at port 0
        @(negedge clk);
        bus.req_valid = 2'b11;
        bus.req_op[0] = 3'b001; bus.req_a[0] = 64'd100; bus.req_b[0] = 64'd7; bus.req_tag[0] = 8'hA0;
        bus.req_op[1] = 3'b011; bus.req_a[1] = 64'd100; bus.req_b[1] = 64'd7; bus.req_tag[1] = 8'hB1;
        acc = 0; rsp_n = 0; n = 0;
        while ((acc < 4 || rsp_n < 4) && n < 400) begin
            #1;
            if (|(bus.req_valid & bus.req_ready)) begin
                chk("arb_grant", 64'(bus.req_ready), (acc % 2 == 1) ? 64'd2 : 64'd1);
                acc++;
            end
            if (bus.rsp_valid) begin
                chk("arb_rsp_port", 64'(bus.rsp_port), 64'(rsp_n % 2));
                chk("arb_rsp_data", bus.rsp_data, (rsp_n % 2 == 1) ? 64'd2 : 64'd14);
                rsp_n++;
            end
            @(posedge clk); #1;
            if (acc == 4) bus.req_valid = 2'b00;
            @(negedge clk);
            n++;
        end
        chk("arb_done", 64'(acc + rsp_n), 64'd8);
        bus.req_valid = 2'b00;

        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp, 0,
                   $sformatf("vec%0d", i), lat);
        end

        // Divide by zero: bypass timing only with the fast path compiled in
        cnt0 = in_valid_cycles;
        do_req(1'b0, 3'b000, 64'd5, 64'd0, 8'h77, 64'hFFFF_FFFF_FFFF_FFFF, 0, "div0", lat);
`ifdef MDIV_DIV_ZERO_FAST_EN
        chk("div0_latency", 64'(lat), 64'd1);
        chk("div0_no_div_valid", 64'(in_valid_cycles - cnt0), 64'd0);
`else
        chk("div0_used_divider", 64'(in_valid_cycles > cnt0), 64'd1);
`endif

        // DIVW overflow with the response stalled for 5 cycles
        do_req(1'b0, 3'b100, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h99,
               64'hFFFF_FFFF_8000_0000, 5, "divw_stall", lat);

        // Flush while the divider is working: that result must never surface
        lat_force = 8;
        issue(1'b0, 3'b000, 64'd1000, 64'd3, 8'h11, "flush_busy", ok, t_acc);
        n = 0;
        while (!dm_busy && n < 50) begin @(negedge clk); n++; end
        chk("flush_busy_started", 64'(dm_busy), 64'd1);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            seen |= bus.rsp_valid;
        end
        chk("flush_busy_no_rsp", 64'(seen), 64'd0);
        chk("flush_busy_div_drained", 64'(dm_busy), 64'd0);
        lat_force = 0;
        do_req(1'b0, 3'b001, 64'd100, 64'd7, 8'h12, 64'd14, 0, "after_flush", lat);

        // Flush in ISSUE before the divider takes the operands
        hold_in = 1'b1;
        hs0 = hs_count;
        issue(1'b1, 3'b001, 64'd50, 64'd5, 8'h21, "flush_issue", ok, t_acc);
        @(negedge clk);
        chk("flush_issue_valid_hi", 64'(div_in_valid), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_issue_valid_lo", 64'(div_in_valid), 64'd0);
        hold_in = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen |= bus.rsp_valid;
        end
        chk("flush_issue_no_rsp", 64'(seen), 64'd0);
        chk("flush_issue_no_hs", 64'(hs_count - hs0), 64'd0);

        // Flush while a response waits
        bus.rsp_ready = 1'b0;
        issue(1'b0, 3'b001, 64'd9, 64'd2, 8'h31, "flush_resp", ok, t_acc);
        wait_rsp("flush_resp", ok);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_resp_drop", 64'(bus.rsp_valid), 64'd0);
        bus.rsp_ready = 1'b1;

        // Flush in IDLE blocks the accept for that cycle
        @(negedge clk);
        bus.req_valid[0] = 1'b1; bus.req_op[0] = 3'b001; bus.req_b[0] = 64'd3;
        bus.flush = 1'b1;
        #1;
        chk("flush_idle_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        chk("flush_idle_no_issue", 64'(div_in_valid | bus.rsp_valid), 64'd0);
        bus.flush = 1'b0;
        bus.req_valid = 2'b00;

        // Randomized traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            rp  = 1'($urandom_range(0, 1));
            rop = 3'($urandom_range(0, 7));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: begin ra = 64'($signed(32'($urandom_range(0, 2000)) - 32'd1000)); rb = 64'($urandom_range(1, 20)); end
                1: rb = 64'd0;
                2: begin ra = 64'h8000_0000_0000_0000; rb = '1; end
                3: begin ra = 64'hFFFF_FFFF_8000_0000; rb = 64'h0000_0001_FFFF_FFFF; end
                default: ;
            endcase
            do_req(rp, rop, ra, rb, 8'(i), ref_div(rop, ra, rb), int'($urandom_range(0, 2)),
                   $sformatf("rnd%0d", i), lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
